// File: rtl/toggle_gen_pkg.sv
// toggle_gen_pkg: shared types and helpers for the toggle_gen slice.
//   ch_state_e     - per-channel state (IDLE, RUN, PEND, DONE)
//   TG_RESET_LEVEL - default toggle_out level after reset / reconfiguration
//   tg_ch_w()      - channel-select width for a given channel count (min 1)
// Optional feature macro: TOGGLE_GEN_BURST_EN (burst counting, DONE state).
package toggle_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_DONE = 2'd3
  } ch_state_e;

  localparam logic TG_RESET_LEVEL = 1'b0;

  function automatic int unsigned tg_ch_w(input int unsigned n);
    int unsigned w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/toggle_gen_ch.sv
// toggle_gen_ch: one square-wave channel of toggle_gen.
// Holds half-period P, up-counter C, staged period S and the channel state.
// With TOGGLE_GEN_BURST_EN defined it also holds the remaining-toggle count R,
// the staged burst value and the sticky done flag.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   load_i     configuration accepted for this channel this cycle
//   period_i   requested half-period (0 = stop)
//   burst_i    requested toggle count (only with TOGGLE_GEN_BURST_EN)
//   en_i       count enable
//   out_o      registered square wave
//   pulse_o    one-cycle strobe on every toggle of out_o
//   done_o     sticky burst-complete flag (0 without TOGGLE_GEN_BURST_EN)
//   pend_o     a staged configuration is waiting for the toggle boundary
module toggle_gen_ch
  import toggle_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_LEVEL = TG_RESET_LEVEL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
`ifdef TOGGLE_GEN_BURST_EN
  input  logic [CNT_W-1:0] burst_i,
`endif
  input  logic             en_i,
  output logic             out_o,
  output logic             pulse_o,
  output logic             done_o,
  output logic             pend_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic             out_q, out_d;
  logic             pulse_q, pulse_d;
`ifdef TOGGLE_GEN_BURST_EN
  logic [CNT_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] sb_q, sb_d;
  logic             done_q, done_d;
`endif

  logic terminal;
  logic expire;

  assign terminal = (c_q == (p_q - 1'b1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      out_q   <= RESET_LEVEL;
      pulse_q <= 1'b0;
`ifdef TOGGLE_GEN_BURST_EN
      r_q     <= '0;
      sb_q    <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      s_q     <= s_d;
      out_q   <= out_d;
      pulse_q <= pulse_d;
`ifdef TOGGLE_GEN_BURST_EN
      r_q     <= r_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    s_d     = s_q;
    out_d   = out_q;
    pulse_d = 1'b0;
    expire  = 1'b0;
`ifdef TOGGLE_GEN_BURST_EN
    r_d     = r_q;
    sb_d    = sb_q;
    done_d  = done_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_i) begin
          p_d     = period_i;
          c_d     = '0;
          out_d   = RESET_LEVEL;
          state_d = (period_i != '0) ? ST_RUN : ST_IDLE;
`ifdef TOGGLE_GEN_BURST_EN
          r_d     = burst_i;
          done_d  = 1'b0;
`endif
        end
      end

      ST_RUN: begin
        if (en_i) begin
          if (terminal) begin
            c_d     = '0;
            out_d   = ~out_q;
            pulse_d = 1'b1;
`ifdef TOGGLE_GEN_BURST_EN
            // R==0 means free run; only a nonzero count is consumed.
            if (r_q != '0) begin
              r_d    = r_q - 1'b1;
              expire = (r_q == {{(CNT_W-1){1'b0}}, 1'b1});
            end
`endif
          end else begin
            c_d = c_q + 1'b1;
          end
        end
        if (load_i) begin
          if (expire) begin
            // Burst ends on this toggle, which is already the boundary the
            // new configuration waits for: apply it now, keeping the
            // post-toggle level, instead of staging it.
            p_d     = period_i;
            c_d     = '0;
            state_d = (period_i != '0) ? ST_RUN : ST_IDLE;
`ifdef TOGGLE_GEN_BURST_EN
            r_d     = burst_i;
`endif
          end else begin
            s_d     = period_i;
            state_d = ST_PEND;
`ifdef TOGGLE_GEN_BURST_EN
            sb_d    = burst_i;
`endif
          end
        end else if (expire) begin
          state_d = ST_DONE;
`ifdef TOGGLE_GEN_BURST_EN
          done_d  = 1'b1;
`endif
        end
      end

      ST_PEND: begin
        if (!en_i) begin
          // Not counting, so no boundary to wait for: apply as from IDLE.
          p_d     = s_q;
          c_d     = '0;
          out_d   = RESET_LEVEL;
          state_d = (s_q != '0) ? ST_RUN : ST_IDLE;
`ifdef TOGGLE_GEN_BURST_EN
          r_d     = sb_q;
`endif
        end else if (terminal) begin
          // Normal toggle with the old period, then switch to the staged one.
          p_d     = s_q;
          c_d     = '0;
          out_d   = ~out_q;
          pulse_d = 1'b1;
          state_d = (s_q != '0) ? ST_RUN : ST_IDLE;
`ifdef TOGGLE_GEN_BURST_EN
          r_d     = sb_q;
`endif
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    endcase
  end

  assign out_o   = out_q;
  assign pulse_o = pulse_q;
  assign pend_o  = (state_q == ST_PEND);
`ifdef TOGGLE_GEN_BURST_EN
  assign done_o  = done_q;
`else
  assign done_o  = 1'b0;
`endif

endmodule

// File: rtl/toggle_gen.sv
// toggle_gen: multi-channel programmable square-wave generator.
// Each channel flips toggle_out every P enabled cycles; P is reprogrammed
// through a valid/ready port and takes effect at the next toggle boundary.
// Optional feature macro: TOGGLE_GEN_BURST_EN (per-channel burst count, done).
// Ports:
//   clock         clock, rising edge
//   reset         synchronous active-high reset
//   cfg_valid     configuration request
//   cfg_ready     request accepted when cfg_valid && cfg_ready
//   cfg_ch        target channel (out-of-range requests are accepted and dropped)
//   cfg_period    half-period in cycles, 0 stops the channel
//   cfg_burst     toggle count for burst mode (unused without TOGGLE_GEN_BURST_EN)
//   ch_en         per-channel count enable
//   toggle_out    registered square waves
//   toggle_pulse  one-cycle strobe per toggle_out change
//   done          sticky burst-complete flags (0 without TOGGLE_GEN_BURST_EN)
module toggle_gen
  import toggle_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CH_W        = tg_ch_w(NUM_CH),
  parameter logic        RESET_LEVEL = TG_RESET_LEVEL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_burst,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] toggle_out,
  output logic [NUM_CH-1:0] toggle_pulse,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] pend;

  // Ready defaults high so out-of-range channel selects are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend[i];
        load[i]   = cfg_valid && !pend[i];
      end
    end
  end

`ifndef TOGGLE_GEN_BURST_EN
  logic [CNT_W-1:0] cfg_burst_unused;
  assign cfg_burst_unused = cfg_burst;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    toggle_gen_ch #(
      .CNT_W       (CNT_W),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk_i    (clock),
      .rst_i    (reset),
      .load_i   (load[g]),
      .period_i (cfg_period),
`ifdef TOGGLE_GEN_BURST_EN
      .burst_i  (cfg_burst),
`endif
      .en_i     (ch_en[g]),
      .out_o    (toggle_out[g]),
      .pulse_o  (toggle_pulse[g]),
      .done_o   (done[g]),
      .pend_o   (pend[g])
    );
  end

endmodule

// File: doc/toggle_gen.md
# toggle_gen

Multi-channel programmable square-wave generator: each channel flips its output every P clock cycles, with P reprogrammed at run time through a valid/ready configuration port. Sits beside the test and stimulus logic as the synthesizable, parametrised replacement for free-running behavioural toggle registers. Reprogramming takes effect glitch-free, at the channel's next toggle boundary.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- CNT_W, 16, width of half-period and burst-count fields
- CH_W, $clog2(NUM_CH) (min 1), channel-select width, derived
- RESET_LEVEL, 1'b0, level of every toggle_out after reset or reconfiguration
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
- cfg_ch  in  CH_W  target channel
- cfg_period  in  CNT_W  half-period P in cycles; 0 = channel stopped
- cfg_burst  in  CNT_W  toggle count for burst mode; ignored without TOGGLE_GEN_BURST_EN
- ch_en  in  NUM_CH  per-channel count enable
- toggle_out  out  NUM_CH  registered square-wave outputs
- toggle_pulse  out  NUM_CH  1-cycle strobe coincident with each toggle_out change
- done  out  NUM_CH  sticky burst-complete flag; tied 0 without TOGGLE_GEN_BURST_EN

## Operation
- Per channel: period reg P, counter C (CNT_W), staged period S, state in {IDLE, RUN, PEND, DONE}.
- IDLE: P==0. Config accepted -> P=cfg_period, C=0, toggle_out=RESET_LEVEL; go RUN if cfg_period!=0, else stay IDLE.
- RUN: if ch_en[i]: C increments; at C==P-1, C->0, toggle_out flips, toggle_pulse=1. If !ch_en[i]: C and toggle_out hold. Config accepted -> S=cfg_period, go PEND.
- PEND: counting continues with old P. At terminal count (C==P-1 with ch_en), normal toggle occurs, P=S, C=0, then RUN (or IDLE if S==0, toggle_out held at its post-toggle level).
- PEND with ch_en[i] low: config applied immediately on the next edge (as from IDLE), no toggle.
- cfg_ready = !(state[cfg_ch]==PEND); combinational from cfg_ch. One outstanding staged config per channel.
- cfg_ch ≥ NUM_CH: cfg_ready=1, request accepted and dropped.
- Counter arithmetic unsigned, CNT_W bits; P=1 toggles every enabled cycle; P=2^CNT_W-1 max, no wrap beyond P-1.

## Timing
- Reset: toggle_out=RESET_LEVEL, toggle_pulse=0, done=0, all P/C/S=0, all channels IDLE, cfg_ready=1.
- Config from IDLE/RUN-disabled: visible in state one cycle after acceptance edge.
- First toggle after config with ch_en high: P enabled cycles after acceptance edge (P=5 -> toggle on 5th edge after).
- toggle_pulse and toggle_out change on the same edge; pulse lasts exactly one cycle.
- Config presented on the PEND apply cycle: cfg_ready is low, not accepted; ready rises the following cycle.
- ch_en changes take effect the same cycle they are sampled; no internal pipelining.
- Reset asserted mid-operation: all state returns to reset values on that edge, staged configs discarded.

## Configuration
- TOGGLE_GEN_BURST_EN defined: per-channel remaining-count R loaded with cfg_burst whenever P is loaded. cfg_burst==0 = free run. Each toggle decrements R; toggle taking R to 0 moves channel to DONE, done[i]=1, toggle_out holds. DONE behaves as IDLE for configuration; acceptance clears done[i]. A staged S with burst reloads R at apply.
- Not defined: no R register, no DONE state, cfg_burst unused, done tied 0; all channels free-run.

## Structure
- Package toggle_gen_pkg: channel state enum (ST_IDLE, ST_RUN, ST_PEND, ST_DONE), RESET_LEVEL default constant, CH_W derivation function.
- Sub-module toggle_gen_ch: one channel (P, C, S, R, state, output); top instantiates NUM_CH copies, decodes cfg_ch to a per-channel load strobe, muxes cfg_ready.

## Test plan
- Reset, cfg ch0 P=5, ch_en=1 -> toggle_out[0] flips every 5 cycles, toggle_pulse[0] 1-cycle each, others stay RESET_LEVEL.
- ch0 running P=5, cfg P=3 at C=1 -> cfg_ready low for ch0 until 5-period edge, then period 3; no shortened high/low phase.
- ch_en[1] dropped for 7 cycles mid-count (P=4) -> output and C frozen, resume exactly where left.
- cfg_ch=NUM_CH (NUM_CH=3) -> accepted, no channel changes; P=0 config on running channel -> stops, output held.
- Burst build: ch2 P=2, burst=4 -> exactly 4 toggles, done[2]=1 sticky, output held; new config clears done.
- Reset asserted during PEND on ch0 -> all outputs RESET_LEVEL next edge, cfg_ready=1, staged period lost.
